serial_compare_driver: RTL and testbench

Parallel-side front end for the bit-serial magnitude comparator. It accepts two WIDTH-bit unsigned operands over a valid/ready handshake and clears the comparator. It then shifts both operands out MSB-first, one bit pair per clock, and samples the comparator's one-hot g/e/l flags. The captured result is returned on a valid/ready response channel. The comparator is thus usable as a word-level block by the rest of the lab datapath.

---
 rtl/serial_cmp_pkg.sv | 28 ++
 rtl/serial_compare_driver_piso.sv | 37 +++
 rtl/serial_compare_driver.sv | 154 +++++++++++++++
 tb/tb_serial_compare_driver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial comparator front end.
package serial_cmp_pkg;

    // Driver FSM states; in_ready is asserted only in IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bit positions of the captured comparator flags in the result vector.
    localparam int RES_GT = 2;
    localparam int RES_EQ = 1;
    localparam int RES_LT = 0;

    // Legal parameter ranges.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;
    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 4;

    // True when exactly one of the three flags is set.
    function automatic logic is_onehot3(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/serial_compare_driver_piso.sv
// Parallel-load, MSB-first shift-out register. Zeros are shifted in from
// the bottom, so once every bit has left, the serial output rests at 0.
module operand_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next-state: load wins over shift; shift moves the next bit into the MSB.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    // Shift register storage, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_compare_driver.sv
// Word-level front end for the bit-serial magnitude comparator: accepts an
// operand pair, clears the comparator, shifts both operands MSB-first, waits
// RESULT_LAT cycles, then returns the captured g/e/l flags.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds data stable while valid is high and ready low.
module serial_compare_driver
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RESULT_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_clear,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_l,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic             out_err,
    output logic [1:0]       dbg_state
);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam int WCW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT + 1) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RESULT_LAT - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
            RESULT_LAT < LAT_MIN || RESULT_LAT > LAT_MAX) begin : g_bad_param
            $error("serial_compare_driver: WIDTH or RESULT_LAT out of range");
        end
    endgenerate

    state_t         state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]     res_q, res_d;
    logic           err_q, err_d;
    logic           ser_clear_q, ser_clear_d;
    logic           out_valid_q, out_valid_d;
    logic           load;
    logic           shift;

    // FSM next state, counters, result capture and registered-output values.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        res_d      = res_q;
        err_d      = err_q;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                wait_cnt_d = '0;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Each SHIFT edge retires one bit; the last one zero-fills the PISOs.
                shift = 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    res_d[RES_GT] = cmp_g;
                    res_d[RES_EQ] = cmp_e;
                    res_d[RES_LT] = cmp_l;
                    err_d         = !is_onehot3({cmp_g, cmp_e, cmp_l});
                    wait_cnt_d    = '0;
                    state_d       = RESP;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The comparator is held in clear whenever no operand is in flight.
        ser_clear_d = (state_d == IDLE) || (state_d == RESP);
        out_valid_d = (state_d == RESP);
    end

    // Control and result registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            ser_clear_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            res_q       <= res_d;
            err_q       <= err_d;
            ser_clear_q <= ser_clear_d;
            out_valid_q <= out_valid_d;
        end
    end

    operand_piso #(.WIDTH(WIDTH)) u_piso_a (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_a),
        .sout  (ser_a)
    );

    operand_piso #(.WIDTH(WIDTH)) u_piso_b (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_b),
        .sout  (ser_b)
    );

    assign in_ready  = (state_q == IDLE);
    assign ser_clear = ser_clear_q;
    assign out_valid = out_valid_q;
    assign out_gt    = res_q[RES_GT];
    assign out_eq    = res_q[RES_EQ];
    assign out_lt    = res_q[RES_LT];
    assign out_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_compare_driver.sv
// Bench for serial_compare_driver: two instances (WIDTH=8/LAT=1 and
// WIDTH=1/LAT=3), each paired with a behavioural serial comparator.
module tb_serial_compare_driver;
    import serial_cmp_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- instance 0: WIDTH=8, RESULT_LAT=1 ----------------
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_a = '0, in_b = '0;
    logic       ser_a, ser_b, ser_clear;
    logic       cmp_g, cmp_e, cmp_l;
    logic       out_valid, out_ready = 1'b1;
    logic       out_gt, out_eq, out_lt, out_err;
    logic [1:0] dbg_state;
    logic       force_err = 1'b0;

    serial_compare_driver #(.WIDTH(8), .RESULT_LAT(1)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .ser_a(ser_a), .ser_b(ser_b), .ser_clear(ser_clear),
        .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt), .out_err(out_err),
        .dbg_state(dbg_state)
    );

    // Behavioural MSB-first comparator: the first differing bit decides.
    logic m_g, m_e, m_l;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_g <= 1'b0; m_e <= 1'b1; m_l <= 1'b0;
        end else if (ser_clear) begin
            m_g <= 1'b0; m_e <= 1'b1; m_l <= 1'b0;
        end else if (m_e && (ser_a != ser_b)) begin
            m_g <= ser_a; m_l <= ser_b; m_e <= 1'b0;
        end
    end
    assign cmp_g = m_g | force_err;
    assign cmp_l = m_l | force_err;
    assign cmp_e = m_e & ~force_err;

    // ---------------- instance 1: WIDTH=1, RESULT_LAT=3 ----------------
    logic       in_valid1 = 1'b0, in_ready1;
    logic [0:0] in_a1 = '0, in_b1 = '0;
    logic       ser_a1, ser_b1, ser_clear1;
    logic       cmp_g1, cmp_e1, cmp_l1;
    logic       out_valid1;
    logic       out_gt1, out_eq1, out_lt1, out_err1;
    logic [1:0] dbg_state1;

    serial_compare_driver #(.WIDTH(1), .RESULT_LAT(3)) u_dut1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .ser_a(ser_a1), .ser_b(ser_b1), .ser_clear(ser_clear1),
        .cmp_g(cmp_g1), .cmp_e(cmp_e1), .cmp_l(cmp_l1),
        .out_valid(out_valid1), .out_ready(1'b1),
        .out_gt(out_gt1), .out_eq(out_eq1), .out_lt(out_lt1), .out_err(out_err1),
        .dbg_state(dbg_state1)
    );

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmp_g1 <= 1'b0; cmp_e1 <= 1'b1; cmp_l1 <= 1'b0;
        end else if (ser_clear1) begin
            cmp_g1 <= 1'b0; cmp_e1 <= 1'b1; cmp_l1 <= 1'b0;
        end else if (cmp_e1 && (ser_a1 != ser_b1)) begin
            cmp_g1 <= ser_a1; cmp_l1 <= ser_b1; cmp_e1 <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    // Expected result word is {gt, eq, lt, err}.
    localparam logic [3:0] R_GT  = 4'b1000;
    localparam logic [3:0] R_EQ  = 4'b0100;
    localparam logic [3:0] R_LT  = 4'b0010;
    localparam logic [3:0] R_ERR = 4'b1011;

    logic [3:0] exp_q[$];
    int         acc_q[$];
    logic [3:0] exp1_q[$];
    int         acc1_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance 0: latency on valid rise, fields on handshake.
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) check("unexpected_valid", 1, 0);
                else check("latency", cyc - acc_q.pop_front(), 9);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else check("result", {out_gt, out_eq, out_lt, out_err}, exp_q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    // Monitor for instance 1 (always ready).
    logic prev_valid1 = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid1 && !prev_valid1) begin
                if (acc1_q.size() == 0) check("unexpected_valid1", 1, 0);
                else check("latency1", cyc - acc1_q.pop_front(), 4);
                if (exp1_q.size() == 0) check("unexpected_result1", 1, 0);
                else check("result1", {out_gt1, out_eq1, out_lt1, out_err1}, exp1_q.pop_front());
            end
        end
        prev_valid1 = out_valid1;
    end

    // ---------------- drivers (called at a negedge) ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] exp);
        int t = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && t < 100) begin @(negedge clock); t++; end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic a, input logic b, input logic [3:0] exp);
        int t = 0;
        in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
        while (!in_ready1 && t < 100) begin @(negedge clock); t++; end
        if (!in_ready1) begin
            check("accept_timeout1", 0, 1);
            in_valid1 = 1'b0;
            return;
        end
        exp1_q.push_back(exp);
        acc1_q.push_back(cyc + 1);
        @(negedge clock);
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clock);
        while (!(in_ready && !out_valid && in_ready1 && !out_valid1) && t < 200) begin
            @(negedge clock); t++;
        end
        check("idle_timeout", (t < 200) ? 1 : 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] bits_a;
        int t;
        int prev_acc;

        // Reset state.
        #12;
        check("rst_ser_clear", ser_clear, 1);
        check("rst_ser_ab", {ser_a, ser_b}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fields", {out_gt, out_eq, out_lt, out_err}, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", dbg_state, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 1: equal operands; serial stream check.
        bits_a = 8'h5A;
        send(8'h5A, 8'h5A, R_EQ);
        for (int i = 0; i < 8; i++) begin
            check("ser_a_bit", ser_a, bits_a[7-i]);
            check("ser_b_bit", ser_b, bits_a[7-i]);
            check("ser_clear_shift", ser_clear, 0);
            check("in_ready_busy", in_ready, 0);
            if (i < 7) @(negedge clock);
        end
        wait_idle();

        // 2: A greater, decided on the MSB.
        send(8'h80, 8'h7F, R_GT);
        check("first_pair", {ser_a, ser_b}, 2'b10);
        wait_idle();

        // 3: A less, result held under back-pressure.
        out_ready = 1'b0;
        send(8'h01, 8'h02, R_LT);
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clock); t++; end
        check("hold_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_valid", out_valid, 1);
            check("hold_fields", {out_gt, out_eq, out_lt, out_err}, R_LT);
            check("hold_in_ready", in_ready, 0);
        end
        #1 out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_fields_kept", {out_gt, out_eq, out_lt, out_err}, R_LT);

        // 4: asynchronous reset at SHIFT bit 3 aborts the operation.
        send(8'hFF, 8'hFF, R_EQ);
        repeat (4) @(negedge clock);
        check("pre_abort_ser", {ser_a, ser_b, ser_clear}, 3'b110);
        #2 reset = 1'b0;
        #1;
        check("abort_ser_clear", ser_clear, 1);
        check("abort_ser_ab", {ser_a, ser_b}, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(8'h10, 8'h0F, R_GT);
        wait_idle();

        // 5a: non-one-hot flags at the sample edge.
        force_err = 1'b1;
        send(8'h00, 8'h00, R_ERR);
        wait_idle();
        force_err = 1'b0;

        // 5b: WIDTH=1, RESULT_LAT=3 instance.
        send1(1'b1, 1'b0, R_GT);
        wait_idle();
        send1(1'b0, 1'b1, R_LT);
        wait_idle();
        send1(1'b1, 1'b1, R_EQ);
        wait_idle();

        // 6: back-to-back offers, accepts spaced WIDTH+RESULT_LAT+2 cycles.
        in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44;
        prev_acc = 0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!in_ready && t < 100) begin @(negedge clock); t++; end
            check("b2b_accept_seen", in_ready, 1);
            check("b2b_gap_clear", ser_clear, 1);
            if (k > 0) check("b2b_spacing", cyc - prev_acc, 11);
            prev_acc = cyc;
            exp_q.push_back(R_LT);
            acc_q.push_back(cyc + 1);
            @(negedge clock);
        end
        in_valid = 1'b0;
        wait_idle();

        check("queue_empty", exp_q.size() + exp1_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
